// File: rtl/axi_lite_wr_regs.sv
// AXI-Lite write-side register bank: captures a cs transfer pulse, updates one register, returns bresp.
// Optional byte-strobe writes are enabled by defining AXIL_WR_REGS_WSTRB_EN.
module axi_lite_wr_regs #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int NREGS  = 8,
  localparam int IDX_W  = (NREGS > 1) ? $clog2(NREGS) : 1,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              areset_i,
  input  logic              cs_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [STRB_W-1:0] wstrb_i,
  output logic              busy_o,
  output logic              bvalid_o,
  input  logic              bready_i,
  output logic [1:0]        bresp_o,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam logic [31:0] NREGS_U     = 32'(NREGS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, WRITE, RESP} state_e;

  state_e              state_q;
  logic [ADDR_W-3:0]   widx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                bvalid_q;
  logic [1:0]          bresp_q;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [DATA_W-1:0]   rd_data_q;
  logic                idx_ok;
  logic                rd_ok;

  // Byte offset within a word carries no meaning here.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr_i[1:0];

`ifdef AXIL_WR_REGS_WSTRB_EN
  logic [STRB_W-1:0] wstrb_q;

  function automatic logic [DATA_W-1:0] merge_word(input logic [DATA_W-1:0] old_word);
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int b = 0; b < STRB_W; b++) begin
      if (wstrb_q[b]) res[8*b +: 8] = wdata_q[8*b +: 8];
    end
    return res;
  endfunction
`else
  logic unused_wstrb;
  assign unused_wstrb = ^wstrb_i;

  function automatic logic [DATA_W-1:0] merge_word(input logic [DATA_W-1:0] old_word);
    logic unused_old;
    unused_old = ^old_word;
    return wdata_q;
  endfunction
`endif

  assign idx_ok    = 32'(widx_q) < NREGS_U;
  assign rd_ok     = 32'(rd_idx_i) < NREGS_U;
  assign busy_o    = (state_q != IDLE);
  assign bvalid_o  = bvalid_q;
  assign bresp_o   = bresp_q;
  assign rd_data_o = rd_data_q;

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      state_q  <= IDLE;
      widx_q   <= '0;
      wdata_q  <= '0;
`ifdef AXIL_WR_REGS_WSTRB_EN
      wstrb_q  <= '0;
`endif
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_i) begin
            widx_q  <= addr_i[ADDR_W-1:2];
            wdata_q <= wdata_i;
`ifdef AXIL_WR_REGS_WSTRB_EN
            wstrb_q <= wstrb_i;
`endif
            state_q <= WRITE;
          end
        end
        WRITE: begin
          bresp_q  <= idx_ok ? RESP_OKAY : RESP_SLVERR;
          bvalid_q <= 1'b1;
          state_q  <= RESP;
        end
        RESP: begin
          if (bready_i) begin
            bvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          bvalid_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (state_q == WRITE && idx_ok) begin
      for (int i = 0; i < NREGS; i++) begin
        if (32'(widx_q) == 32'(i)) regs_q[i] <= merge_word(regs_q[i]);
      end
    end
  end

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_ok ? regs_q[rd_idx_i] : '0;
    end
  end

endmodule

// File: tb/tb_axi_lite_wr_regs.sv
// Randomized bench for axi_lite_wr_regs against an array-based register model.
module tb_axi_lite_wr_regs;

  logic        clk;
  logic        areset;
  logic        cs;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        busy;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [2:0]  rd_idx;
  logic [31:0] rd_data;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] model [8];

  axi_lite_wr_regs #(.ADDR_W(8), .DATA_W(32), .NREGS(8)) dut (
    .clk_i(clk), .areset_i(areset), .cs_i(cs), .addr_i(addr), .wdata_i(wdata),
    .wstrb_i(wstrb), .busy_o(busy), .bvalid_o(bvalid), .bready_i(bready),
    .bresp_o(bresp), .rd_idx_i(rd_idx), .rd_data_o(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference rule: a valid index updates the word, strobed bytes only when strobes are honoured.
  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    if (idx < 8) begin
`ifdef AXIL_WR_REGS_WSTRB_EN
      for (int b = 0; b < 4; b++)
        if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
`else
      model[idx] = d;
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int delay, input bit spurious);
    int          idx;
    logic [2:0]  ridx;
    logic [1:0]  exp_resp;
    logic [31:0] old_val, new_val;
    idx      = int'(a[7:2]);
    ridx     = (idx < 8) ? 3'(idx) : 3'd0;
    exp_resp = (idx < 8) ? 2'b00 : 2'b10;
    old_val  = model[ridx];
    model_write(idx, d, s);
    new_val  = model[ridx];

    check("idle_busy", {63'd0, busy}, 64'd0);
    cs = 1'b1; addr = a; wdata = d; wstrb = s;
    bready = (delay == 0);
    rd_idx = ridx;
    tick();
    cs = 1'b0;
    check("wr_busy", {63'd0, busy}, 64'd1);
    check("wr_bvalid", {63'd0, bvalid}, 64'd0);
    tick();
    check("resp_bvalid", {63'd0, bvalid}, 64'd1);
    check("resp_bresp", {62'd0, bresp}, {62'd0, exp_resp});
    check("resp_busy", {63'd0, busy}, 64'd1);
    check("rd_old", {32'd0, rd_data}, {32'd0, old_val});
    for (int k = 0; k < delay; k++) begin
      tick();
      cs = 1'b0;
      check("hold_bvalid", {63'd0, bvalid}, 64'd1);
      check("hold_bresp", {62'd0, bresp}, {62'd0, exp_resp});
      check("hold_busy", {63'd0, busy}, 64'd1);
      if (k == 0) check("rd_new_hold", {32'd0, rd_data}, {32'd0, new_val});
      if (spurious && k == 1 && delay >= 3) begin
        cs = 1'b1; addr = {3'd0, ridx, 2'b00}; wdata = ~new_val; wstrb = 4'hF;
      end
      if (k == delay - 1) bready = 1'b1;
    end
    tick();
    cs = 1'b0;
    bready = 1'b0;
    check("done_bvalid", {63'd0, bvalid}, 64'd0);
    check("done_busy", {63'd0, busy}, 64'd0);
    check("rd_new", {32'd0, rd_data}, {32'd0, new_val});
  endtask

  task automatic read_check(input int idx, input string tag);
    rd_idx = 3'(idx);
    tick();
    check(tag, {32'd0, rd_data}, {32'd0, model[idx]});
  endtask

  initial begin
    logic [7:0]  ra;
    logic [31:0] rd;
    logic [3:0]  rs;
    for (int i = 0; i < 8; i++) model[i] = '0;
    areset = 1'b1; cs = 1'b0; addr = '0; wdata = '0; wstrb = '0; bready = 1'b0; rd_idx = '0;
    #23;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_bvalid", {63'd0, bvalid}, 64'd0);
    check("rst_bresp", {62'd0, bresp}, 64'd0);
    check("rst_rd_data", {32'd0, rd_data}, 64'd0);
    tick();
    areset = 1'b0;
    tick();

    do_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 1'b0);
    check("reg1_basic", {32'd0, model[1]}, 64'hDEADBEEF);
    do_write(8'h04, 32'h11223344, 4'b0101, 0, 1'b0);
`ifdef AXIL_WR_REGS_WSTRB_EN
    read_check(1, "reg1_strobe");
    check("model_strobe", {32'd0, model[1]}, 64'hDE22BE44);
`else
    read_check(1, "reg1_full");
    check("model_full", {32'd0, model[1]}, 64'h11223344);
`endif
    do_write(8'h40, 32'hCAFEF00D, 4'hF, 1, 1'b0);
    for (int i = 0; i < 8; i++) read_check(i, "slverr_unchanged");
    do_write(8'h1E, 32'hA5A55A5A, 4'hF, 10, 1'b1);
    read_check(7, "spurious_ignored");

    for (int t = 0; t < 60; t++) begin
      ra = 8'($urandom_range(0, 8'h7F));
      rd = $urandom;
      rs = 4'($urandom);
      do_write(ra, rd, rs, int'($urandom_range(0, 4)), 1'($urandom));
    end
    for (int i = 0; i < 8; i++) read_check(i, "rand_final");

    // Reset while a response is outstanding.
    do_write(8'h08, 32'h0BADF00D, 4'hF, 0, 1'b0);
    rd_idx = 3'd2;
    cs = 1'b1; addr = 8'h0C; wdata = 32'h12345678; wstrb = 4'hF; bready = 1'b0;
    tick();
    cs = 1'b0;
    tick();
    check("pre_rst_bvalid", {63'd0, bvalid}, 64'd1);
    #2;
    areset = 1'b1;
    #1;
    check("arst_bvalid", {63'd0, bvalid}, 64'd0);
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_rd_data", {32'd0, rd_data}, 64'd0);
    for (int i = 0; i < 8; i++) model[i] = '0;
    tick();
    areset = 1'b0;
    tick();
    check("post_rst_busy", {63'd0, busy}, 64'd0);
    for (int i = 0; i < 8; i++) read_check(i, "post_rst_reg");
    do_write(8'h14, 32'h600DCAFE, 4'hF, 2, 1'b0);
    read_check(5, "post_rst_write");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
